// File: rtl/onchip_mem_stream_reader.sv
// rtl/onchip_mem_stream_reader.sv - CSR-programmed RAM read master emitting one sop/eop packet per transfer.
// The FIFO absorbs the RAM's 1-cycle read latency so the issue rule alone prevents overflow.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_nx;

  logic [ADDR_W-1:0] start_q, addr_q;
  logic [ADDR_W:0]   len_q, issued_q, beat_q;
  logic              irq_en_q, done_q, aborted_q, inflight_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              busy, ctrl_wr, go_req, abort_req, issue, pop, last_beat;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata[31:ADDR_W+1];
  assign busy         = (state_q != IDLE);
  assign ctrl_wr      = csr_write && (csr_address == 2'd2);
  // abort takes precedence over go when both arrive in one write
  assign go_req       = ctrl_wr && csr_writedata[0] && !csr_writedata[2] && !busy;
  assign abort_req    = ctrl_wr && csr_writedata[2] && busy;

  assign st_valid     = (count_q != '0);
  assign pop          = st_valid && st_ready;
  assign last_beat    = (beat_q == len_q - (ADDR_W+1)'(1));
  assign st_data      = st_valid ? fifo_mem[rd_ptr] : '0;
  assign st_sop       = st_valid && (beat_q == '0);
  assign st_eop       = st_valid && last_beat;
  assign mem_address  = addr_q;
  assign mem_chipselect = issue;
  assign mem_clken    = 1'b1;
  assign irq          = done_q && irq_en_q;

  always_comb begin
    state_nx = state_q;
    issue    = 1'b0;
    case (state_q)
      IDLE:  if (go_req) state_nx = (len_q == '0) ? DONE : RUN;
      RUN: begin
        // count the read issued last cycle, its data has not landed yet
        issue = (({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH));
        if (issue && (issued_q + (ADDR_W+1)'(1) == len_q)) state_nx = DRAIN;
      end
      DRAIN: if (pop && last_beat) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_req) state_nx = IDLE;
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      2'd0: rd_mux = 32'(start_q);
      2'd1: rd_mux = 32'(len_q);
      2'd2: rd_mux = {30'd0, irq_en_q, 1'b0};
      default: rd_mux = {29'd0, aborted_q, done_q, busy};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      issued_q     <= '0;
      beat_q       <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      inflight_q   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      csr_readdata <= '0;
    end else begin
      state_q      <= state_nx;
      csr_readdata <= csr_read ? rd_mux : '0;
      if (csr_write && csr_address == 2'd0 && !busy) start_q <= csr_writedata[ADDR_W-1:0];
      if (csr_write && csr_address == 2'd1 && !busy) len_q <= csr_writedata[ADDR_W:0];
      if (ctrl_wr) irq_en_q <= csr_writedata[1];
      if (csr_write && csr_address == 2'd3) begin
        if (csr_writedata[1]) done_q <= 1'b0;
        if (csr_writedata[2]) aborted_q <= 1'b0;
      end
      if (state_q == DONE) done_q <= 1'b1;
      if (abort_req) begin
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
      end

      if (go_req) begin
        addr_q   <= start_q;
        issued_q <= '0;
        beat_q   <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + ADDR_W'(1);
          issued_q <= issued_q + (ADDR_W+1)'(1);
        end
        if (pop) beat_q <= beat_q + (ADDR_W+1)'(1);
      end

      inflight_q <= issue && !abort_req;
      if (abort_req) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (inflight_q) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({inflight_q, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inflight_q) fifo_mem[wr_ptr] <= mem_readdata;
  end
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// tb/tb_onchip_mem_stream_reader.sv - Directed bench with a queue-based packet model for the stream reader.
module tb_onchip_mem_stream_reader;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        csr_address = '0;
  logic              csr_write = 1'b0;
  logic [31:0]       csr_writedata = '0;
  logic              csr_read = 1'b0;
  logic [31:0]       csr_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_clken;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic [DATA_W-1:0] st_data;
  logic              st_valid, st_sop, st_eop, irq;
  logic              st_ready = 1'b1;

  always #5 clk = ~clk;

  onchip_mem_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_read(csr_read), .csr_readdata(csr_readdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop), .irq(irq)
  );

  function automatic logic [31:0] ram_word(input int a);
    logic [13:0] w;
    w = a[13:0];
    return {16'hD00D, 2'b00, w};
  endfunction

  always @(posedge clk) if (mem_chipselect) mem_readdata <= ram_word(int'(mem_address));

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  logic [33:0] exp_q[$];
  logic [13:0] exp_addr[$];
  logic [13:0] addr_log[$];
  int          issued_n, accepted_n;
  logic [31:0] first_data;
  bit          got_first, eop_seen, skip_stab;
  logic        prev_valid, prev_ready, prev_sop, prev_eop;
  logic [31:0] prev_data;
  int          ready_mode = 0;

  task automatic plan(input int start, input int len);
    exp_q.delete();
    exp_addr.delete();
    addr_log.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(14'((start + i) % 16384));
      exp_q.push_back({i == 0, i == len - 1, ram_word((start + i) % 16384)});
    end
    issued_n = 0;
    accepted_n = 0;
    got_first = 0;
    eop_seen = 0;
  endtask

  always @(posedge clk) begin
    #1;
    st_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_chipselect) begin
        check("fifo_room", 64'(issued_n - accepted_n < DEPTH), 64'd1);
        addr_log.push_back(mem_address);
        if (exp_addr.size() == 0) fail_now("unexpected_read");
        else check("read_addr", 64'(mem_address), 64'(exp_addr.pop_front()));
      end
      if (!skip_stab && prev_valid && !prev_ready) begin
        if (!st_valid) fail_now("valid_dropped_under_backpressure");
        else check("hold_stable", {st_sop, st_eop, st_data}, {prev_sop, prev_eop, prev_data});
      end
      if (st_valid && st_ready) begin
        accepted_n++;
        if (!got_first) begin
          first_data = st_data;
          got_first = 1;
        end
        if (st_eop) eop_seen = 1;
        if (exp_q.size() == 0) fail_now("extra_beat");
        else check("beat", {st_sop, st_eop, st_data}, 64'(exp_q.pop_front()));
      end
      if (mem_chipselect) issued_n++;
      prev_valid = st_valid;
      prev_ready = st_ready;
      prev_sop = st_sop;
      prev_eop = st_eop;
      prev_data = st_data;
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    csr_address = a; csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic start_xfer(input int start, input int len, input logic irq_en);
    csr_wr(2'd0, 32'(start));
    csr_wr(2'd1, 32'(len));
    plan(start, len);
    csr_wr(2'd2, {30'd0, irq_en, 1'b1});
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) fail_now("timeout_waiting_for_beats");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (accepted_n < n && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (accepted_n < n) fail_now("timeout_waiting_for_accepts");
  endtask

  logic [31:0] rd;
  int          held;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_st_valid", st_valid, 0);
    check("rst_outputs", {mem_chipselect, st_sop, st_eop, irq, st_data, csr_readdata},
          64'd0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_clken", mem_clken, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    csr_rd(2'd3, rd); check("rst_status", rd, 0);
    csr_rd(2'd1, rd); check("rst_length", rd, 0);

    // basic 8-beat transfer, irq enabled, latency pinned
    start_xfer(32'h10, 8, 1'b1);
    check("latency_c0", st_valid, 0);
    @(posedge clk); #1; check("latency_c1", st_valid, 0);
    @(posedge clk); #1; check("latency_c2", st_valid, 1);
    wait_done();
    check("first_data_0x10", first_data, 32'hD00D0010);
    check("eop_seen_8", eop_seen, 1);
    check("accepted_8", accepted_n, 8);
    csr_rd(2'd3, rd); check("status_done_8", rd, 32'h2);
    check("irq_set", irq, 1);
    csr_wr(2'd3, 32'h2);
    check("irq_cleared", irq, 0);
    csr_rd(2'd3, rd); check("status_w1c", rd, 0);

    // address wrap at the top of the RAM
    start_xfer(32'h3FFE, 4, 1'b0);
    wait_done();
    check("wrap_a0", addr_log[0], 14'h3FFE);
    check("wrap_a1", addr_log[1], 14'h3FFF);
    check("wrap_a2", addr_log[2], 14'h0000);
    check("wrap_a3", addr_log[3], 14'h0001);
    check("first_data_wrap", first_data, 32'hD00D3FFE);
    check("irq_disabled", irq, 0);
    csr_rd(2'd3, rd); check("status_done_wrap", rd, 32'h2);
    csr_wr(2'd3, 32'h6);

    // random backpressure
    ready_mode = 1;
    start_xfer(32'h100, 16, 1'b0);
    wait_done();
    ready_mode = 0;
    check("accepted_16", accepted_n, 16);
    check("issued_16", issued_n, 16);
    csr_rd(2'd3, rd); check("status_done_16", rd, 32'h2);
    csr_wr(2'd3, 32'h6);

    // single beat
    start_xfer(32'h2222, 1, 1'b0);
    wait_done();
    check("first_data_len1", first_data, 32'hD00D2222);
    check("eop_seen_len1", eop_seen, 1);
    csr_rd(2'd3, rd); check("status_done_len1", rd, 32'h2);
    csr_wr(2'd3, 32'h6);

    // zero length
    start_xfer(32'h40, 0, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("len0_no_reads", issued_n, 0);
    check("len0_no_beats", accepted_n, 0);
    check("len0_irq", irq, 1);
    csr_rd(2'd3, rd); check("status_len0", rd, 32'h2);
    csr_wr(2'd3, 32'h6);

    // go and abort in the same write start nothing
    csr_wr(2'd1, 32'd100);
    plan(0, 0);
    csr_wr(2'd2, 32'h5);
    repeat (5) @(posedge clk); #1;
    check("goabort_no_beats", accepted_n, 0);
    csr_rd(2'd3, rd); check("status_goabort", rd, 0);

    // abort mid-packet, plus START write ignored while busy
    start_xfer(32'h200, 100, 1'b0);
    csr_wr(2'd0, 32'h1234);
    csr_rd(2'd0, rd); check("start_locked_busy", rd, 32'h200);
    wait_beats(10);
    skip_stab = 1;
    csr_wr(2'd2, 32'h4);
    check("abort_valid_low", st_valid, 0);
    check("abort_no_read", mem_chipselect, 0);
    held = accepted_n;
    repeat (5) @(posedge clk); #1;
    check("abort_no_more_beats", accepted_n, held);
    check("abort_no_eop", eop_seen, 0);
    csr_rd(2'd3, rd); check("status_aborted", rd, 32'h6);
    csr_wr(2'd3, 32'h6);
    csr_rd(2'd3, rd); check("status_abort_w1c", rd, 0);
    plan(0, 0);
    skip_stab = 0;

    // reset mid-transfer, then a clean rerun
    start_xfer(32'h300, 20, 1'b1);
    wait_beats(5);
    skip_stab = 1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {st_valid, mem_chipselect, irq, st_sop, st_eop, st_data, csr_readdata},
          64'd0);
    reset = 1'b0;
    plan(0, 0);
    csr_rd(2'd3, rd); check("midrst_status", rd, 0);
    csr_rd(2'd1, rd); check("midrst_length", rd, 0);
    skip_stab = 0;
    start_xfer(32'h10, 8, 1'b0);
    wait_done();
    check("rerun_first", first_data, 32'hD00D0010);
    check("rerun_accepted", accepted_n, 8);
    csr_rd(2'd3, rd); check("rerun_status", rd, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
